// File: rtl/vga_dot_clock_gen.sv
// -----------------------------------------------------------------------------
// vga_dot_clock_gen
//
// Fractional-N dot-clock generator for the VGA timing path. A phase
// accumulator advances by a constant increment on every board clock edge.
// The accumulator MSB, registered, becomes the dot clock. A one-board-cycle
// strobe marks each dot-clock rising edge, so downstream VGA logic can stay
// on the board clock and use the strobe as a clock enable.
//
// Parameters
//   BOARD_HZ    board clock frequency in Hz
//   DOT_HZ      target dot-clock frequency in Hz (0 < DOT_HZ <= BOARD_HZ/2)
//   ACC_W       phase accumulator width (8..32)
//   LOCK_CYCLES dot-clock rising edges after reset before locked (1..65535)
//
// Ports
//   board     in   board clock; every flop uses its rising edge
//   rst_n     in   asynchronous active-low reset
//   dotclock  out  generated dot clock, taken directly from a flop
//   dot_stb   out  single-cycle pulse in the cycle dotclock is newly high
//   locked    out  high once LOCK_CYCLES strobes have occurred since reset
// -----------------------------------------------------------------------------
module vga_dot_clock_gen #(
    parameter int BOARD_HZ    = 50_000_000,
    parameter int DOT_HZ      = 25_000_000,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 16
) (
    input  logic board,
    input  logic rst_n,
    output logic dotclock,
    output logic dot_stb,
    output logic locked
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    // The ratio test is done as 2*DOT_HZ > BOARD_HZ in 64 bits so an odd
    // BOARD_HZ is judged exactly rather than through a truncated BOARD_HZ/2.
    localparam longint DOT_L   = longint'(DOT_HZ);
    localparam longint BOARD_L = longint'(BOARD_HZ);

    generate
        if (BOARD_HZ <= 0) begin : g_bad_board
            $error("vga_dot_clock_gen: BOARD_HZ must be positive");
        end
        if (DOT_HZ <= 0 || (2 * DOT_L) > BOARD_L) begin : g_bad_dot
            $error("vga_dot_clock_gen: DOT_HZ must satisfy 0 < DOT_HZ <= BOARD_HZ/2");
        end
        if (ACC_W < 8 || ACC_W > 32) begin : g_bad_accw
            $error("vga_dot_clock_gen: ACC_W must be within 8..32");
        end
        if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
            $error("vga_dot_clock_gen: LOCK_CYCLES must be within 1..65535");
        end
    endgenerate

    // Widths and divisors fall back to harmless values when a parameter is
    // illegal, so elaboration reaches the $error above instead of tripping
    // over a negative width or a division by zero first.
    localparam int     W       = (ACC_W >= 8 && ACC_W <= 32) ? ACC_W : 24;
    localparam longint BOARD_D = (BOARD_HZ > 0) ? BOARD_L : 64'sd1;

    // -------------------------------------------------------------------------
    // Phase increment, rounded to nearest:
    //   INC = floor((DOT_HZ * 2^W + BOARD_HZ/2) / BOARD_HZ)
    // With DOT_HZ <= BOARD_HZ/2 this is at most 2^(W-1), so it always fits
    // in W bits and the MSB can never skip a 0->1 transition.
    // -------------------------------------------------------------------------
    localparam longint INC_WIDE = ((DOT_L <<< W) + (BOARD_D / 2)) / BOARD_D;
    localparam logic [W-1:0] INC = INC_WIDE[W-1:0];

    localparam logic [15:0] LOCK_TARGET = 16'(LOCK_CYCLES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic         dotclock_q;
    logic         dotclock_d;
    logic         dot_stb_q;
    logic         dot_stb_d;
    logic [15:0]  lock_cnt_q;
    logic [15:0]  lock_cnt_d;
    logic         locked_q;
    logic         locked_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Accumulator wraps naturally modulo 2^W.
        acc_d = acc_q + INC;

        // dotclock follows the MSB of the value being loaded, so it changes
        // on the same edge as the accumulator and needs no extra delay stage.
        dotclock_d = acc_d[W-1];

        // Rising MSB only; a wrap (MSB 1->0) yields a falling edge, no strobe.
        dot_stb_d = acc_d[W-1] & ~acc_q[W-1];

        // Saturating strobe counter; it freezes at the lock target.
        lock_cnt_d = lock_cnt_q;
        if (dot_stb_d && (lock_cnt_q != LOCK_TARGET)) begin
            lock_cnt_d = lock_cnt_q + 16'd1;
        end

        // Comparing the next count makes locked rise on the same edge as the
        // LOCK_CYCLES-th strobe. The counter never leaves the target once
        // reached, so locked stays high until reset.
        locked_d = (lock_cnt_d == LOCK_TARGET);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge board or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            dotclock_q <= 1'b0;
            dot_stb_q  <= 1'b0;
            lock_cnt_q <= 16'd0;
            locked_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            dotclock_q <= dotclock_d;
            dot_stb_q  <= dot_stb_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all straight from flops, so dotclock is glitch-free and has
    // zero skew relative to dot_stb.
    // -------------------------------------------------------------------------
    assign dotclock = dotclock_q;
    assign dot_stb  = dot_stb_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_vga_dot_clock_gen.sv
// -----------------------------------------------------------------------------
// Testbench for vga_dot_clock_gen. Three instances share the board clock and
// reset: defaults (50/25 MHz), a 75/25 MHz fractional ratio, and LOCK_CYCLES=1.
// Expected outputs come from closed-form arithmetic on the edge count since
// reset release, plus a table of hand-written vectors for the default run.
// -----------------------------------------------------------------------------
module tb_vga_dot_clock_gen;

    localparam longint unsigned INC_DEF = 64'd8388608;  // 2^23
    localparam longint unsigned INC_75  = 64'd5592405;
    localparam int              W       = 24;
    localparam int              LONG_RUN = 45000;      // board edges for the 75 MHz run

    logic board;
    logic rst_n;

    logic dot_def, stb_def, lck_def;
    logic dot_75,  stb_75,  lck_75;
    logic dot_lc1, stb_lc1, lck_lc1;

    int total = 0;
    int bad   = 0;

    // Edges with rst_n high since the most recent reset.
    longint unsigned k = 0;

    vga_dot_clock_gen u_def (
        .board    (board),
        .rst_n    (rst_n),
        .dotclock (dot_def),
        .dot_stb  (stb_def),
        .locked   (lck_def)
    );

    vga_dot_clock_gen #(
        .BOARD_HZ (75_000_000),
        .DOT_HZ   (25_000_000)
    ) u_75 (
        .board    (board),
        .rst_n    (rst_n),
        .dotclock (dot_75),
        .dot_stb  (stb_75),
        .locked   (lck_75)
    );

    vga_dot_clock_gen #(
        .LOCK_CYCLES (1)
    ) u_lc1 (
        .board    (board),
        .rst_n    (rst_n),
        .dotclock (dot_lc1),
        .dot_stb  (stb_lc1),
        .locked   (lck_lc1)
    );

    initial board = 1'b0;
    always #5 board = ~board;

    // ---------------------------------------------------------------- model
    // After k edges the phase is k*INC. The dot clock is bit W-1 of it; the
    // number of rising crossings so far is floor((k*INC + 2^(W-1)) / 2^W).
    function automatic bit model_dot(longint unsigned kk, longint unsigned inc);
        return bit'(((kk * inc) >> (W - 1)) & 64'd1);
    endfunction

    function automatic longint unsigned model_rises(longint unsigned kk, longint unsigned inc);
        return (kk * inc + (64'd1 << (W - 1))) >> W;
    endfunction

    function automatic bit model_stb(longint unsigned kk, longint unsigned inc);
        if (kk == 0) return 1'b0;
        return model_rises(kk, inc) != model_rises(kk - 1, inc);
    endfunction

    function automatic bit model_lck(longint unsigned kk, longint unsigned inc, int lc);
        return model_rises(kk, inc) >= longint'(lc);
    endfunction

    // ---------------------------------------------------------------- checks
    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("def_dot", dot_def, model_dot(k, INC_DEF));
        chk("def_stb", stb_def, model_stb(k, INC_DEF));
        chk("def_lck", lck_def, model_lck(k, INC_DEF, 16));
        chk("r75_dot", dot_75,  model_dot(k, INC_75));
        chk("r75_stb", stb_75,  model_stb(k, INC_75));
        chk("r75_lck", lck_75,  model_lck(k, INC_75, 16));
        chk("lc1_dot", dot_lc1, model_dot(k, INC_DEF));
        chk("lc1_stb", stb_lc1, model_stb(k, INC_DEF));
        chk("lc1_lck", lck_lc1, model_lck(k, INC_DEF, 1));
    endtask

    // One board edge, then compare on the falling edge.
    task automatic step();
        @(posedge board);
        if (rst_n) k++;
        @(negedge board);
        check_all();
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        int edge_no;
        bit dot;
        bit stb;
        bit lck;
        bit lck1;
    } vec_t;

    vec_t tbl[8];

    // 75 MHz run statistics
    longint unsigned last_stb_k;
    int              stb_count;
    bit              prev_stb;

    initial begin
        int offset;
        int hold;
        int waited;

        tbl[0] = '{1,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{2,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{3,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{4,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{29, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{30, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{31, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{32, 1'b0, 1'b0, 1'b1, 1'b1};

        // Hold reset for 100 board cycles: everything stays at zero.
        rst_n = 1'b0;
        k     = 0;
        for (int i = 0; i < 100; i++) step();

        // Release between edges.
        rst_n      = 1'b1;
        last_stb_k = 0;
        stb_count  = 0;
        prev_stb   = 1'b0;

        // Table-driven default sequence.
        for (int i = 0; i < 8; i++) begin
            while (k < longint'(tbl[i].edge_no)) begin
                step();
                if (stb_75) begin
                    stb_count++;
                    last_stb_k = k;
                end
                prev_stb = stb_75;
            end
            chk("tbl_dot",  dot_def, tbl[i].dot);
            chk("tbl_stb",  stb_def, tbl[i].stb);
            chk("tbl_lck",  lck_def, tbl[i].lck);
            chk("tbl_lck1", lck_lc1, tbl[i].lck1);
        end

        // Long 75/25 MHz run: strobe spacing, no back-to-back strobes, count.
        while (k < longint'(LONG_RUN)) begin
            step();
            if (stb_75) begin
                if (last_stb_k != 0) begin
                    total++;
                    if ((k - last_stb_k) != 3 && (k - last_stb_k) != 4) begin
                        bad++;
                        $display("FAIL r75_interval k=%0d got=%0d want=3or4", k, k - last_stb_k);
                    end
                end
                total++;
                if (prev_stb) begin
                    bad++;
                    $display("FAIL r75_back_to_back k=%0d got=1 want=0", k);
                end
                stb_count++;
                last_stb_k = k;
            end
            prev_stb = stb_75;
        end
        total++;
        if (stb_count < (LONG_RUN / 3) - 1 || stb_count > (LONG_RUN / 3) + 1) begin
            bad++;
            $display("FAIL r75_count got=%0d want=%0d+-1", stb_count, LONG_RUN / 3);
        end

        // Asynchronous resets at random points between edges.
        for (int r = 0; r < 6; r++) begin
            if (r == 0) begin
                // Wait (bounded) for locked=1 with dotclock=1 on the default unit.
                waited = 0;
                while (!(lck_def && dot_def) && waited < 8) begin
                    step();
                    waited++;
                end
                total++;
                if (!(lck_def && dot_def)) begin
                    bad++;
                    $display("FAIL wait_lock_high got=%b%b want=11", lck_def, dot_def);
                end
            end else begin
                hold = $urandom_range(20, 120);
                for (int i = 0; i < hold; i++) step();
            end

            offset = $urandom_range(1, 3);
            @(posedge board);
            #(offset);
            rst_n = 1'b0;
            k     = 0;
            #1;
            check_all();   // outputs must already be clear, before any edge

            hold = $urandom_range(1, 5);
            for (int i = 0; i < hold; i++) step();
            rst_n = 1'b1;  // currently at a falling edge

            // The default sequence must repeat, including locked at edge 31.
            for (int i = 0; i < 30; i++) step();
            chk("rst_lck_e30", lck_def, 1'b0);
            step();
            chk("rst_lck_e31", lck_def, 1'b1);
            chk("rst_stb_e31", stb_def, 1'b1);
            for (int i = 0; i < 8; i++) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
